// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and widths.
// Used by the write-back arbiter and its load FIFO.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 1 << REG_AW;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NREG-1:0] rd_onehot(
    input logic [REG_AW-1:0] rd
  );
    rd_onehot = NREG'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus: ALU result, load handshake, regfile write, pending mask.
// master = producers/observers, slave = the arbiter.
interface wb_arbiter_if
  import mips_pkg::*;
();

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;

  logic              reg_write;
  logic [REG_AW-1:0] w_reg0;
  logic [DATA_W-1:0] w_data;

  logic [NREG-1:0]   pending;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  reg_write, w_reg0, w_data,
    input  pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output reg_write, w_reg0, w_data,
    output pending
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of load results with kill-by-rd and live mask.
// Ports: push/pop, kill+kill_rd, head entry, count, live_mask.
module wb_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [REG_AW-1:0] push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill,
  input  logic [REG_AW-1:0] kill_rd,
  output wb_entry_t         head,
  output logic [CW-1:0]     count,
  output logic [NREG-1:0]   live_mask
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill && mem[i].live &&
            mem[i].rd == kill_rd)
          mem[i].live <= 1'b0;
      // Popped slots go dead so the
      // live mask only sees queued entries.
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) begin
        mem[wr_ptr] <= '{
          live: 1'b1,
          rd:   push_rd,
          data: push_data
        };
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= count + CW'(push)
                     - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    live_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i].live)
        live_mask |= rd_onehot(mem[i].rd);
    live_mask[0] = 1'b0;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(push && count == CW'(DEPTH))
  );

  a_no_underflow: assert property (
    @(posedge clk) disable iff (reset)
    !(pop && count == '0)
  );

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and load results onto the single regfile write port.
// Ports: clk, reset, wb (slave) carrying ALU, load, write and pending.
module wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  wb
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         head;
  logic [CW-1:0]     count;
  logic [NREG-1:0]   live_mask;

  logic              alu_wr;
  logic              ld_acc;
  logic              push;
  logic              pop;
  logic              head_wr;
  logic              nonempty;

  logic              reg_write_q;
  logic [REG_AW-1:0] w_reg0_q;
  logic [DATA_W-1:0] w_data_q;

  assign wb.ld_ready =
    (count < CW'(DEPTH)) && !reset;

  assign alu_wr =
    wb.alu_valid && wb.alu_rd != REG_ZERO;

  assign ld_acc = wb.ld_valid && wb.ld_ready;

  // A same-cycle ALU write to the same rd
  // is younger, so the load is dropped.
  assign push = ld_acc &&
    wb.ld_rd != REG_ZERO &&
    !(wb.alu_valid && wb.alu_rd == wb.ld_rd);

  assign nonempty = count != '0;

  // A dead head is always drained; a live
  // head waits while the ALU owns the port.
  assign pop = nonempty &&
    (!head.live || !alu_wr);

  assign head_wr = nonempty &&
    head.live && !alu_wr;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (wb.ld_rd),
    .push_data (wb.ld_data),
    .pop       (pop),
    .kill      (alu_wr),
    .kill_rd   (wb.alu_rd),
    .head      (head),
    .count     (count),
    .live_mask (live_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      w_reg0_q    <= '0;
      w_data_q    <= '0;
    end else begin
      unique case (1'b1)
        alu_wr: begin
          reg_write_q <= 1'b1;
          w_reg0_q    <= wb.alu_rd;
          w_data_q    <= wb.alu_data;
        end
        head_wr: begin
          reg_write_q <= 1'b1;
          w_reg0_q    <= head.rd;
          w_data_q    <= head.data;
        end
        default: begin
          reg_write_q <= 1'b0;
          w_reg0_q    <= '0;
          w_data_q    <= '0;
        end
      endcase
    end
  end

  assign wb.reg_write = reg_write_q;
  assign wb.w_reg0    = w_reg0_q;
  assign wb.w_data    = w_data_q;
  assign wb.pending   = live_mask;

endmodule
